pulse_train_generator: RTL and testbench
========================================

// Module: pulse_train_generator
// PURPOSE
//   Generates edges for the edge detector to consume.
//   - A one-cycle start strobe launches a train of N pulses on out_signal.
//   - High and low widths are programmable, in clock cycles.
//   - Used as stimulus source and loopback partner for the edge detector.
// PARAMETERS
//   WIDTH_BITS  8  width of in_high_cycles / in_low_cycles and phase counter
//   COUNT_BITS  8  width of in_pulse_count and remaining-pulse counter
// PORTS
//   in_clock        input   1           single system clock, rising edge
//   in_reset        input   1           asynchronous, active-high reset
//   in_start        input   1           one-cycle strobe; launches a train when idle
//   in_high_cycles  input   WIDTH_BITS  high-phase length; 0 treated as 1
//   in_low_cycles   input   WIDTH_BITS  low-phase length between pulses; 0 treated as 1
//   in_pulse_count  input   COUNT_BITS  pulses per train; 0 = empty train
//   out_signal      output  1           generated waveform, registered
//   out_busy        output  1           train in progress
//   out_done        output  1           one-cycle strobe, train finished
// BEHAVIOUR
//   Reset (async, active-high)
//   - out_signal=0, out_busy=0, out_done=0; FSM=IDLE; all counters 0.
//   - Reset mid-train aborts immediately; no out_done is produced.
//   FSM states: IDLE, HIGH, LOW, DONE
//   - IDLE: in_start=1 latches all three config inputs.
//     - count>0: go to HIGH.
//     - count=0: go to DONE.
//   - HIGH: out_signal=1 for exactly max(H,1) cycles.
//     - Remaining pulses>1: go to LOW and decrement remaining.
//     - Otherwise: go to DONE.
//   - LOW: out_signal=0 for exactly max(L,1) cycles, then go to HIGH.
//   - DONE: out_done=1 for one cycle, then go to IDLE.
//   Outputs
//   - All outputs are registered, decoded from the state register.
//   - out_signal rises on the first clock edge after start is accepted (1-cycle latency).
//   - out_busy=1 in HIGH and LOW only.
//   - No trailing low phase after the last pulse: DONE directly follows the last HIGH cycle.
//   - The DONE cycle has out_signal=0, out_busy=0.
//   - Total train length = N*H' + (N-1)*L' cycles, where H'=max(H,1), L'=max(L,1).
//   Boundary rules
//   - in_start while in HIGH, LOW or DONE is ignored, not queued.
//   - in_start in the same cycle DONE exits is also ignored; a new train needs start in IDLE.
//   - Config inputs are sampled only at start acceptance; later changes do not affect the running train.
//   - Counters never wrap: the phase counter loads H'-1 / L'-1 and counts down to 0.
//   - Max widths: H=2^WIDTH_BITS-1 and N=2^COUNT_BITS-1 are legal.
// CONFIGURATION
//   Macro PULSE_TRAIN_ABORT_EN
//   - Defined:
//     - Adds input in_abort (1 bit, after in_start in the port list).
//     - in_abort=1 in HIGH, LOW or DONE forces IDLE on the next edge.
//     - That edge sets out_signal=0 and out_busy=0; no out_done is produced.
//     - in_abort in IDLE has no effect.
//     - in_abort has priority over in_start in the same cycle.
//   - Undefined: port absent; trains always run to completion.
// TESTING
//   1. Reset: assert in_reset mid-HIGH phase -> out_signal, out_busy, out_done all 0 immediately (async); stay idle after release.
//   2. Basic train: H=2, L=3, N=3, pulse start -> pattern 110001100011, then out_done for 1 cycle; 12 busy cycles.
//   3. Zero cases:
//      - N=0 -> no out_signal activity; out_done 1 cycle after start.
//      - H=0, L=0, N=2 -> pattern 101, then done.
//   4. Start ignored: restart during LOW of H=1, L=4, N=2 train -> waveform unchanged.
//      - Change H mid-train -> still old widths.
//   5. Loopback: out_signal into edge_detector in_signal, N=5 -> exactly 5 out_strobe pulses, one per rising edge.
//   6. PULSE_TRAIN_ABORT_EN: abort on 2nd HIGH cycle of H=4, N=2 -> out_signal 0 next cycle; no out_done.
//      - Abort+start together in HIGH -> abort wins.

Source files
------------

// File: rtl/pulse_train_generator.sv
// Pulse train generator: a start strobe launches N pulses of programmable high/low width; optional abort via PULSE_TRAIN_ABORT_EN.
// Latency: out_signal rises on the first edge after start is accepted; out_done directly follows the last high cycle.
// Backpressure: none; in_start is honoured only in IDLE and is otherwise dropped, never queued.
module pulse_train_generator #(
  parameter int WIDTH_BITS = 8,
  parameter int COUNT_BITS = 8
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_start,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic                  in_abort,
`endif
  input  logic [WIDTH_BITS-1:0] in_high_cycles,
  input  logic [WIDTH_BITS-1:0] in_low_cycles,
  input  logic [COUNT_BITS-1:0] in_pulse_count,
  output logic                  out_signal,
  output logic                  out_busy,
  output logic                  out_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH_BITS-1:0] PHASE_ZERO = '0;
  localparam logic [WIDTH_BITS-1:0] PHASE_ONE  = WIDTH_BITS'(1);
  localparam logic [COUNT_BITS-1:0] COUNT_ZERO = '0;
  localparam logic [COUNT_BITS-1:0] COUNT_ONE  = COUNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [WIDTH_BITS-1:0]   phase_q, phase_d;
  // Phase reload values are held as width-1 so a zero width behaves as one.
  logic [WIDTH_BITS-1:0]   high_len_q, high_len_d;
  logic [WIDTH_BITS-1:0]   low_len_q, low_len_d;
  logic [COUNT_BITS-1:0]   remain_q, remain_d;
  logic                    signal_d, busy_d, done_d;
  logic                    abort;

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort = in_abort;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [WIDTH_BITS-1:0] len_minus_one(input logic [WIDTH_BITS-1:0] len);
    return (len == PHASE_ZERO) ? PHASE_ZERO : (len - PHASE_ONE);
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    remain_d   = remain_q;

    case (state_q)
      IDLE: begin
        if (in_start) begin
          high_len_d = len_minus_one(in_high_cycles);
          low_len_d  = len_minus_one(in_low_cycles);
          remain_d   = in_pulse_count;
          if (in_pulse_count != COUNT_ZERO) begin
            state_d = HIGH;
            phase_d = len_minus_one(in_high_cycles);
          end else begin
            state_d = DONE;
            phase_d = PHASE_ZERO;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_d  = IDLE;
          phase_d  = PHASE_ZERO;
          remain_d = COUNT_ZERO;
        end else if (phase_q != PHASE_ZERO) begin
          phase_d = phase_q - PHASE_ONE;
        end else if (remain_q > COUNT_ONE) begin
          state_d  = LOW;
          phase_d  = low_len_q;
          remain_d = remain_q - COUNT_ONE;
        end else begin
          // Last pulse: no trailing low phase.
          state_d  = DONE;
          remain_d = COUNT_ZERO;
        end
      end

      LOW: begin
        if (abort) begin
          state_d  = IDLE;
          phase_d  = PHASE_ZERO;
          remain_d = COUNT_ZERO;
        end else if (phase_q != PHASE_ZERO) begin
          phase_d = phase_q - PHASE_ONE;
        end else begin
          state_d = HIGH;
          phase_d = high_len_q;
        end
      end

      DONE: begin
        // Start arriving here is dropped; a new train needs start in IDLE.
        state_d  = IDLE;
        phase_d  = PHASE_ZERO;
        remain_d = COUNT_ZERO;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_comb begin
    signal_d = (state_d == HIGH);
    busy_d   = (state_d == HIGH) || (state_d == LOW);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q    <= IDLE;
      phase_q    <= PHASE_ZERO;
      high_len_q <= PHASE_ZERO;
      low_len_q  <= PHASE_ZERO;
      remain_q   <= COUNT_ZERO;
      out_signal <= 1'b0;
      out_busy   <= 1'b0;
      out_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      remain_q   <= remain_d;
      out_signal <= signal_d;
      out_busy   <= busy_d;
      out_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: stimulus queues expected trains, a negedge monitor checks each one at out_done.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
`ifdef PULSE_TRAIN_ABORT_EN
  logic       abort;
`endif
  logic [7:0] hi, lo, cnt;
  logic       sig, busy, done;

  pulse_train_generator #(.WIDTH_BITS(8), .COUNT_BITS(8)) dut (
    .in_clock       (clk),
    .in_reset       (rst),
    .in_start       (start),
`ifdef PULSE_TRAIN_ABORT_EN
    .in_abort       (abort),
`endif
    .in_high_cycles (hi),
    .in_low_cycles  (lo),
    .in_pulse_count (cnt),
    .out_signal     (sig),
    .out_busy       (busy),
    .out_done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           start_cyc;
    int           len;
    logic [511:0] pat;
    int           nrise;
    string        name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: accumulates the busy waveform and rising edges, scores it when out_done appears.
  bit           active = 0;
  bit           prev_done = 0;
  bit           m_prev = 0;
  int           m_first = 0;
  int           m_len = 0;
  int           m_rise = 0;
  logic [511:0] m_pat = '0;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      active    = 0;
      prev_done = 0;
    end else begin
      if (done) begin
        chk("done_one_cycle", {511'd0, prev_done}, 512'd0);
        chk("done_quiet", {510'd0, sig, busy}, 512'd0);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done at cycle %0d, expected no done", cyc);
        end else begin
          e = q.pop_front();
          if (!active) begin
            m_len  = 0;
            m_pat  = '0;
            m_rise = 0;
          end
          chk({e.name, "_len"}, 512'(m_len), 512'(e.len));
          chk({e.name, "_pattern"}, m_pat, e.pat);
          chk({e.name, "_rising_edges"}, 512'(m_rise), 512'(e.nrise));
          chk({e.name, "_done_cycle"}, 512'(cyc), 512'(e.start_cyc + 1 + e.len));
          if (e.len > 0) chk({e.name, "_first_busy"}, 512'(m_first), 512'(e.start_cyc + 1));
        end
      end
      if (busy) begin
        if (!active) begin
          active  = 1;
          m_first = cyc;
          m_len   = 0;
          m_pat   = '0;
          m_rise  = 0;
          m_prev  = 0;
        end
        m_pat = {m_pat[510:0], sig};
        m_len++;
        if (sig && !m_prev) m_rise++;
        m_prev = sig;
      end else begin
        active = 0;
      end
      prev_done = done;
    end
  end

  task automatic launch(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                        input bit push, input int len, input logic [511:0] pat,
                        input int nrise, input string nm);
    exp_t x;
    @(posedge clk); #1;
    hi = h; lo = l; cnt = n; start = 1'b1;
    if (push) begin
      x.start_cyc = cyc;
      x.len       = len;
      x.pat       = pat;
      x.nrise     = nrise;
      x.name      = nm;
      q.push_back(x);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("drain_pending", 512'(q.size()), 512'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [511:0] p;

  initial begin
    rst = 1'b1; start = 1'b0; hi = '0; lo = '0; cnt = '0;
`ifdef PULSE_TRAIN_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_signal", 512'(sig), 512'd0);
    chk("reset_busy", 512'(busy), 512'd0);
    chk("reset_done", 512'(done), 512'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic train H=2 L=3 N=3
    launch(8'd2, 8'd3, 8'd3, 1, 12, 512'b110001100011, 3, "basic");
    wait_drain(100);

    // Empty train and zero widths
    launch(8'd5, 8'd5, 8'd0, 1, 0, 512'd0, 0, "n_zero");
    wait_drain(100);
    launch(8'd0, 8'd0, 8'd2, 1, 3, 512'b101, 2, "hl_zero");
    wait_drain(100);

    // Restart during LOW plus a mid-train width change must not disturb the train
    launch(8'd1, 8'd4, 8'd2, 1, 6, 512'b100001, 2, "restart_ignored");
    @(posedge clk); #1 start = 1'b1; hi = 8'd7; lo = 8'd9; cnt = 8'd4;
    @(posedge clk); #1 start = 1'b0;
    wait_drain(100);

    // Start presented while in DONE is dropped
    launch(8'd1, 8'd1, 8'd1, 1, 1, 512'b1, 1, "done_exit");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_drain(100);
    repeat (6) @(posedge clk);
    #1 chk("done_exit_no_restart", 512'(busy), 512'd0);

    // Loopback-style rising edge count
    launch(8'd3, 8'd2, 8'd5, 1, 23, 512'b11100111001110011100111, 5, "loopback");
    wait_drain(200);

    // Maximum widths and counts
    p = {1'b0, {511{1'b1}}} & ~(512'd1 << 255);
    launch(8'd255, 8'd1, 8'd2, 1, 511, p, 2, "max_high");
    wait_drain(1000);
    p = {128{4'h5}} & ((512'd1 << 509) - 512'd1);
    launch(8'd0, 8'd0, 8'd255, 1, 509, p, 255, "max_count");
    wait_drain(1000);

    // Async reset mid-HIGH aborts without done
    launch(8'd5, 8'd1, 8'd2, 0, 0, 512'd0, 0, "reset_abort");
    #3 rst = 1'b1;
    #1;
    chk("async_reset_signal", 512'(sig), 512'd0);
    chk("async_reset_busy", 512'(busy), 512'd0);
    chk("async_reset_done", 512'(done), 512'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("post_reset_idle", {510'd0, sig, busy}, 512'd0);

`ifdef PULSE_TRAIN_ABORT_EN
    // Abort on the second HIGH cycle
    launch(8'd4, 8'd1, 8'd2, 0, 0, 512'd0, 0, "abort_high");
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_signal", 512'(sig), 512'd0);
    chk("abort_busy", 512'(busy), 512'd0);
    repeat (8) @(posedge clk);
    #1 chk("abort_stays_idle", {510'd0, sig, busy}, 512'd0);

    // Abort and start together while HIGH: abort wins
    launch(8'd4, 8'd1, 8'd2, 0, 0, 512'd0, 0, "abort_start");
    #1 abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", {510'd0, sig, busy}, 512'd0);
    repeat (3) @(posedge clk);
    #1 chk("abort_start_idle", 512'(busy), 512'd0);
`endif

    repeat (5) @(posedge clk);
    chk("final_queue_empty", 512'(q.size()), 512'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
